instruction_fetch_param: RTL and testbench
==========================================

# instruction_fetch_param

Parametrised, loadable instruction fetch stage for the 3-bit-word pipelined CPU. Replaces the compile-time program constants with a program memory written at run time through a word-serial load port, and supports configurable word width and depth. Each fetch reads an opcode/operand pair at the pointer supplied by the execute stage. Program end and misaligned pointers are detected and reported to the downstream decode/execute stages.

## Interface
- `WORD_W`, 3: width of one program word (opcode or operand).
- `DEPTH`, 16: program memory depth in words; must be even and ≥ 2.
- `PTR_W`, `$clog2(DEPTH)`: instruction pointer width.
- `clk`  input  1  clock; all logic on rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `load_start`  input  1  pulse; clears the program and enters LOAD.
- `load_valid`  input  1  `load_data` holds a valid word this cycle.
- `load_data`  input  WORD_W  program word, written in ascending address order.
- `load_last`  input  1  qualifies `load_valid`; marks the final word.
- `load_ready`  output  1  high in LOAD; words are accepted only while high.
- `restart`  input  1  pulse; re-runs the stored program from END or FAULT.
- `halt`  input  1  freezes the fetch stage.
- `instr_ptr`  input  PTR_W  address of the opcode to fetch.
- `opcode`  output  WORD_W  fetched opcode (registered).
- `operand`  output  WORD_W  fetched operand (registered).
- `instr_ptr_if_reg`  output  PTR_W  pointer associated with `opcode`/`operand`.
- `fetch_valid`  output  1  `opcode`/`operand` are valid for decode.
- `prog_done`  output  1  sticky; the pointer ran past the program end.
- `fault`  output  1  sticky; an odd (misaligned) pointer was presented.

## Operation
- Storage: `DEPTH` × `WORD_W` register array. `wr_ptr` has width PTR_W+1 and `prog_len` has width PTR_W+1, so `prog_len` can equal DEPTH.
- States: IDLE, LOAD, RUN, END, FAULT. The reset state is IDLE.
- Priority: `rst` > `load_start` > `restart` > `halt` > normal operation.
- IDLE
  - `prog_len`=0; no fetches are performed.
  - `load_start` → LOAD.
- LOAD
  - `load_ready`=1.
  - Each `load_valid` writes `mem[wr_ptr]` and increments `wr_ptr`.
  - Exit to RUN when `load_valid` && (`load_last` || `wr_ptr`==DEPTH-1). On exit, `prog_len`=`wr_ptr`+1.
  - `load_start` received in LOAD resets `wr_ptr` to 0 and stays in LOAD.
  - Memory contents beyond `prog_len` are don't-care.
- RUN, with `halt`=0, evaluated each cycle on the current `instr_ptr`:
  - If `instr_ptr[0]`=1: go to FAULT, set `fault`=1, `fetch_valid`=0.
  - Else if `instr_ptr`+1 ≥ `prog_len` (computed in PTR_W+1 bits, so no wrap): go to END, set `prog_done`=1, `fetch_valid`=0.
  - Otherwise: `opcode`←`mem[ip]`, `operand`←`mem[ip+1]`, `instr_ptr_if_reg`←`ip`, `fetch_valid`←1.
- RUN, with `halt`=1: every register holds its value, including `fetch_valid` and the state.
- END and FAULT
  - Flags are sticky; `fetch_valid`=0; `halt` has no effect.
  - `restart` → RUN and clears `prog_done`/`fault`; the program is kept.
  - `load_start` → LOAD and clears the flags.
- `load_start` in RUN aborts the program. That cycle it forces `fetch_valid`←0 and `prog_len`←0.
- `restart` in IDLE, LOAD or RUN is ignored.

## Timing
- Reset values of all outputs: `opcode`=0, `operand`=0, `instr_ptr_if_reg`=0, `fetch_valid`=0, `prog_done`=0, `fault`=0, `load_ready`=0.
- Fetch latency is 1 cycle: `instr_ptr` sampled at edge N gives its outputs after edge N.
- A new pointer is accepted every cycle; there are no bubbles.
- `load_ready` is a registered, state-decoded output. It rises the cycle after the `load_start` edge.
- The last load word is written at edge N. RUN begins after edge N, so the first fetch can be sampled at edge N+1. Outputs are valid after N+1.
- `load_valid` while `load_ready`=0 is ignored.
- `prog_done` and `fault` assert 1 cycle after the offending pointer is sampled.
- `restart` sampled at edge N: RUN begins after edge N, and the first fetch result is valid after edge N+1.
- Reset mid-LOAD or mid-RUN returns to IDLE and discards `prog_len`. Memory is not cleared.

## Test plan
- Reset: assert `rst` 2 cycles with random inputs → all outputs 0, state IDLE; `instr_ptr`=0 with no program gives `fetch_valid`=0.
- Load and fetch
  - Stimulus: load 2,4,1,1,7,5 (`load_last` on the 5); drive ip=0,2,4.
  - Required: (2,4), (1,1), (7,5) with `fetch_valid`=1 and `instr_ptr_if_reg`=0,2,4 on consecutive cycles.
  - Then drive ip=6 → `prog_done`=1 and `fetch_valid`=0 next cycle; it stays sticky.
- Misaligned: program loaded, ip=3 → `fault`=1 next cycle; `opcode`/`operand` hold their previous value; `restart` → RUN, `fault`=0.
- Halt: hold `halt`=1 for 3 cycles while ip changes → outputs frozen; release → the fetch for the current ip appears next cycle.
- Full depth: 16 `load_valid` words with no `load_last` → auto-exit to RUN; `prog_len`=16; ip=14 returns `mem[14]`/`mem[15]`, and ip=16 is not representable.
- Abort: `load_start` mid-RUN together with `restart` → LOAD wins, `fetch_valid`=0; the reloaded 2-word program fetches correctly.

Source files
------------

// File: rtl/instruction_fetch_param.sv
// Loadable instruction fetch stage: a run-time-written program memory plus a
// one-cycle opcode/operand fetch with end-of-program and misalignment detection.
module instruction_fetch_param #(
  parameter int WORD_W = 3,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [WORD_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              restart,
  input  logic              halt,
  input  logic [PTR_W-1:0]  instr_ptr,
  output logic [WORD_W-1:0] opcode,
  output logic [WORD_W-1:0] operand,
  output logic [PTR_W-1:0]  instr_ptr_if_reg,
  output logic              fetch_valid,
  output logic              prog_done,
  output logic              fault
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_END, S_FAULT} state_t;

  localparam logic [PTR_W:0] ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] LAST = (PTR_W+1)'(DEPTH-1);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic              mem_we;

  state_t            state_q, state_d;
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    prog_len_q, prog_len_d;
  logic [WORD_W-1:0] opcode_q, opcode_d;
  logic [WORD_W-1:0] operand_q, operand_d;
  logic [PTR_W-1:0]  ipr_q, ipr_d;
  logic              fv_q, fv_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;
  logic              ready_q, ready_d;

  // Operand address: the pointer is even whenever a fetch happens, so ip+1 is ip|1.
  logic [PTR_W-1:0]  ip_odd;
  logic [PTR_W:0]    ip_next;
  assign ip_odd  = {instr_ptr[PTR_W-1:1], 1'b1};
  assign ip_next = {1'b0, instr_ptr} + ONE;

  // Program memory write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem_q[wr_ptr_q[PTR_W-1:0]] <= load_data;
  end

  // Next-state, load bookkeeping and fetch datapath.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    prog_len_d = prog_len_q;
    opcode_d   = opcode_q;
    operand_d  = operand_q;
    ipr_d      = ipr_q;
    fv_d       = fv_q;
    done_d     = done_q;
    fault_d    = fault_q;
    mem_we     = 1'b0;
    if (load_start) begin
      state_d    = S_LOAD;
      wr_ptr_d   = '0;
      prog_len_d = '0;
      fv_d       = 1'b0;
      done_d     = 1'b0;
      fault_d    = 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          fv_d = 1'b0;
          if (load_valid) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + ONE;
            if (load_last || wr_ptr_q == LAST) begin
              state_d    = S_RUN;
              prog_len_d = wr_ptr_q + ONE;
            end
          end
        end
        S_RUN: begin
          if (!halt) begin
            if (instr_ptr[0]) begin
              state_d = S_FAULT;
              fault_d = 1'b1;
              fv_d    = 1'b0;
            end else if (ip_next >= prog_len_q) begin
              state_d = S_END;
              done_d  = 1'b1;
              fv_d    = 1'b0;
            end else begin
              opcode_d  = mem_q[instr_ptr];
              operand_d = mem_q[ip_odd];
              ipr_d     = instr_ptr;
              fv_d      = 1'b1;
            end
          end
        end
        S_END, S_FAULT: begin
          fv_d = 1'b0;
          if (restart) begin
            state_d = S_RUN;
            done_d  = 1'b0;
            fault_d = 1'b0;
          end
        end
        default: fv_d = 1'b0;
      endcase
    end
    ready_d = (state_d == S_LOAD);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      prog_len_q <= '0;
      opcode_q   <= '0;
      operand_q  <= '0;
      ipr_q      <= '0;
      fv_q       <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      prog_len_q <= prog_len_d;
      opcode_q   <= opcode_d;
      operand_q  <= operand_d;
      ipr_q      <= ipr_d;
      fv_q       <= fv_d;
      done_q     <= done_d;
      fault_q    <= fault_d;
      ready_q    <= ready_d;
    end
  end

  assign load_ready       = ready_q;
  assign opcode           = opcode_q;
  assign operand          = operand_q;
  assign instr_ptr_if_reg = ipr_q;
  assign fetch_valid      = fv_q;
  assign prog_done        = done_q;
  assign fault            = fault_q;

endmodule

// File: tb/tb_instruction_fetch_param.sv
// Bench for instruction_fetch_param: directed scenarios followed by random
// load/run rounds, every cycle compared against a queue-based program model.
module tb_instruction_fetch_param;
  localparam int WORD_W = 3;
  localparam int DEPTH  = 16;
  localparam int PTR_W  = 4;

  logic              clk = 1'b0;
  logic              rst, load_start, load_valid, load_last, load_ready;
  logic              restart, halt, fetch_valid, prog_done, fault;
  logic [WORD_W-1:0] load_data, opcode, operand;
  logic [PTR_W-1:0]  instr_ptr, instr_ptr_if_reg;

  instruction_fetch_param #(.WORD_W(WORD_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .restart(restart), .halt(halt), .instr_ptr(instr_ptr), .opcode(opcode),
    .operand(operand), .instr_ptr_if_reg(instr_ptr_if_reg),
    .fetch_valid(fetch_valid), .prog_done(prog_done), .fault(fault)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: what the stage is doing, the words collected so far,
  // and the program that is currently runnable.
  typedef enum {M_IDLE, M_LOAD, M_RUN, M_END, M_FAULT} mode_t;
  mode_t mode = M_IDLE;
  int    buf_q[$];
  int    prog[$];
  int    e_op = 0, e_opr = 0, e_ipr = 0, e_fv = 0, e_done = 0, e_flt = 0;

  task automatic model();
    int ip;
    ip = int'(instr_ptr);
    if (rst) begin
      mode = M_IDLE; prog.delete(); buf_q.delete();
      e_op = 0; e_opr = 0; e_ipr = 0; e_fv = 0; e_done = 0; e_flt = 0;
    end else if (load_start) begin
      mode = M_LOAD; buf_q.delete(); prog.delete();
      e_fv = 0; e_done = 0; e_flt = 0;
    end else if (mode == M_LOAD) begin
      if (load_valid) begin
        buf_q.push_back(int'(load_data));
        if (load_last || buf_q.size() == DEPTH) begin
          prog = buf_q;
          mode = M_RUN;
        end
      end
    end else if (mode == M_RUN) begin
      if (!halt) begin
        if (ip % 2 == 1) begin
          mode = M_FAULT; e_flt = 1; e_fv = 0;
        end else if (ip + 1 >= prog.size()) begin
          mode = M_END; e_done = 1; e_fv = 0;
        end else begin
          e_op = prog[ip]; e_opr = prog[ip+1]; e_ipr = ip; e_fv = 1;
        end
      end
    end else if (mode == M_END || mode == M_FAULT) begin
      if (restart) begin
        mode = M_RUN; e_done = 0; e_flt = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: model advances on the same inputs, outputs checked 1 ns later.
  task automatic cyc();
    @(posedge clk);
    model();
    #1;
    chk("opcode",      32'(opcode),           32'(e_op));
    chk("operand",     32'(operand),          32'(e_opr));
    chk("ip_if_reg",   32'(instr_ptr_if_reg), 32'(e_ipr));
    chk("fetch_valid", 32'(fetch_valid),      32'(e_fv));
    chk("prog_done",   32'(prog_done),        32'(e_done));
    chk("fault",       32'(fault),            32'(e_flt));
    chk("load_ready",  32'(load_ready),       32'(mode == M_LOAD));
  endtask

  task automatic quiet();
    rst = 0; load_start = 0; load_valid = 0; load_last = 0; restart = 0; halt = 0;
  endtask

  int words[$];

  // Load the words in 'words'; optionally tag the final one with load_last.
  task automatic load_words(input bit use_last, input bit gaps);
    load_start = 1; cyc(); load_start = 0;
    for (int i = 0; i < words.size(); i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        load_valid = 0; load_last = 1'($urandom); load_data = 3'($urandom); cyc();
      end
      load_valid = 1; load_data = 3'(words[i]);
      load_last  = use_last && (i == words.size() - 1);
      cyc();
    end
    load_valid = 0; load_last = 0;
  endtask

  task automatic drive_ip(input int ip);
    instr_ptr = 4'(ip); cyc();
  endtask

  initial begin
    // Reset with random inputs
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      load_start = 1'($urandom); load_valid = 1'($urandom); load_data = 3'($urandom);
      load_last = 1'($urandom); restart = 1'($urandom); halt = 1'($urandom);
      instr_ptr = 4'($urandom);
      cyc();
    end
    quiet(); instr_ptr = 0;
    cyc();
    chk("idle_no_fetch", 32'(fetch_valid), 0);

    // Load 2,4,1,1,7,5 and fetch the three instructions
    words = '{2, 4, 1, 1, 7, 5};
    load_words(1'b1, 1'b0);
    drive_ip(0); chk("tp_op0", 32'(opcode), 2); chk("tp_opr0", 32'(operand), 4);
    drive_ip(2); chk("tp_op2", 32'(opcode), 1); chk("tp_ip2", 32'(instr_ptr_if_reg), 2);
    drive_ip(4); chk("tp_op4", 32'(opcode), 7); chk("tp_opr4", 32'(operand), 5);
    drive_ip(6); chk("tp_done", 32'(prog_done), 1); chk("tp_done_fv", 32'(fetch_valid), 0);
    drive_ip(0); drive_ip(2); chk("tp_done_sticky", 32'(prog_done), 1);

    // Restart, then a misaligned pointer
    restart = 1; cyc(); restart = 0;
    drive_ip(2);
    drive_ip(3); chk("mis_fault", 32'(fault), 1); chk("mis_hold_op", 32'(opcode), 1);
    drive_ip(0);
    restart = 1; cyc(); restart = 0;
    chk("mis_cleared", 32'(fault), 0);
    drive_ip(4);

    // Halt for 3 cycles while the pointer moves
    halt = 1;
    for (int i = 0; i < 3; i++) drive_ip(2 * $urandom_range(0, 7) + $urandom_range(0, 1));
    halt = 0;
    drive_ip(0); chk("halt_release", 32'(opcode), 2);

    // Full depth, no load_last
    words.delete();
    for (int i = 0; i < DEPTH; i++) words.push_back(int'($urandom_range(0, 7)));
    load_words(1'b0, 1'b0);
    drive_ip(14); chk("full_op14", 32'(opcode), 32'(words[14])); chk("full_opr15", 32'(operand), 32'(words[15]));
    drive_ip(0);

    // Abort mid-RUN with simultaneous restart, then reload a 2-word program
    load_start = 1; restart = 1; cyc(); load_start = 0; restart = 0;
    chk("abort_fv", 32'(fetch_valid), 0); chk("abort_ready", 32'(load_ready), 1);
    words = '{6, 3};
    load_valid = 1; load_data = 3'(6); load_last = 0; cyc();
    load_data = 3'(3); load_last = 1; cyc();
    load_valid = 0; load_last = 0;
    drive_ip(0); chk("abort_op", 32'(opcode), 6); chk("abort_opr", 32'(operand), 3);

    // Random rounds: random programs, pointers, halts, restarts and aborts
    for (int r = 0; r < 12; r++) begin
      words.delete();
      for (int i = 0; i < $urandom_range(1, DEPTH); i++) words.push_back(int'($urandom_range(0, 7)));
      load_words(1'($urandom), 1'b1);
      for (int c = 0; c < 30; c++) begin
        halt       = ($urandom_range(0, 5) == 0);
        restart    = ($urandom_range(0, 4) == 0);
        load_valid = 1'($urandom); load_data = 3'($urandom);
        load_start = ($urandom_range(0, 40) == 0);
        if ($urandom_range(0, 7) == 0) instr_ptr = 4'($urandom);
        else instr_ptr = 4'(2 * $urandom_range(0, (words.size() + 1) / 2));
        cyc();
      end
      quiet();
      if ($urandom_range(0, 3) == 0) begin
        rst = 1; cyc(); rst = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
